// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches for the current PC, buffers in-order responses
// with their PC and hands them to decode; a flush discards everything buffered or in flight.
module instr_fetch_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic                  pc_advance,
    input  logic                  flush,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [DATA_WIDTH-1:0] dec_pc,
    output logic                  misaligned
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic                  run_q;
    cnt_t                  inflight_q, inflight_d;
    cnt_t                  drop_cnt_q, drop_cnt_d;
    cnt_t                  outq_cnt_q, outq_cnt_d;
    ptr_t                  pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    ptr_t                  outq_wr_q, outq_wr_d, outq_rd_q, outq_rd_d;
    logic [DATA_WIDTH-1:0] pcq_mem_q    [DEPTH];
    logic [DATA_WIDTH-1:0] outq_pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0] outq_instr_q [DEPTH];
    logic                  misaligned_q, misaligned_d;

    logic [CntW:0]         occupancy;
    logic                  aligned, issue_ok, req_fire;
    logic                  rsp_drop, rsp_keep, dec_fire;

    // Credit counts both in-flight fetches and buffered results so outq can never overflow.
    always_comb begin
        occupancy      = {1'b0, inflight_q} + {1'b0, outq_cnt_q};
        aligned        = (pc_in[1:0] == 2'b00);
        issue_ok       = run_q & ~flush & ~misaligned_q;
        imem_req_valid = issue_ok & aligned & (occupancy < (CntW + 1)'(DEPTH));
        imem_req_addr  = pc_in;
        req_fire       = imem_req_valid & imem_req_ready;
        pc_advance     = req_fire;
        rsp_drop       = imem_rsp_valid & (flush | (drop_cnt_q != '0));
        rsp_keep       = imem_rsp_valid & ~rsp_drop;
        dec_valid      = (outq_cnt_q != '0) & ~flush;
        dec_fire       = dec_valid & dec_ready;
        dec_instr      = outq_instr_q[outq_rd_q];
        dec_pc         = outq_pc_q[outq_rd_q];
        misaligned     = misaligned_q;
    end

    always_comb begin
        inflight_d   = inflight_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
        drop_cnt_d   = drop_cnt_q;
        outq_cnt_d   = outq_cnt_q;
        pcq_wr_d     = pcq_wr_q;
        pcq_rd_d     = pcq_rd_q;
        outq_wr_d    = outq_wr_q;
        outq_rd_d    = outq_rd_q;
        misaligned_d = misaligned_q;
        if (flush) begin
            // Every fetch still outstanding after this edge belongs to the wrong path.
            drop_cnt_d   = inflight_q - cnt_t'(imem_rsp_valid);
            outq_cnt_d   = '0;
            pcq_wr_d     = '0;
            pcq_rd_d     = '0;
            outq_wr_d    = '0;
            outq_rd_d    = '0;
            misaligned_d = 1'b0;
        end else begin
            if (req_fire) begin
                pcq_wr_d = pcq_wr_q + ptr_t'(1);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - cnt_t'(1);
            end
            if (rsp_keep) begin
                pcq_rd_d  = pcq_rd_q + ptr_t'(1);
                outq_wr_d = outq_wr_q + ptr_t'(1);
            end
            if (dec_fire) begin
                outq_rd_d = outq_rd_q + ptr_t'(1);
            end
            outq_cnt_d = outq_cnt_q + cnt_t'(rsp_keep) - cnt_t'(dec_fire);
            if (issue_ok && !aligned) begin
                misaligned_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            inflight_q   <= '0;
            drop_cnt_q   <= '0;
            outq_cnt_q   <= '0;
            pcq_wr_q     <= '0;
            pcq_rd_q     <= '0;
            outq_wr_q    <= '0;
            outq_rd_q    <= '0;
            misaligned_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pcq_mem_q[i]    <= '0;
                outq_pc_q[i]    <= '0;
                outq_instr_q[i] <= '0;
            end
        end else begin
            run_q        <= 1'b1;
            inflight_q   <= inflight_d;
            drop_cnt_q   <= drop_cnt_d;
            outq_cnt_q   <= outq_cnt_d;
            pcq_wr_q     <= pcq_wr_d;
            pcq_rd_q     <= pcq_rd_d;
            outq_wr_q    <= outq_wr_d;
            outq_rd_q    <= outq_rd_d;
            misaligned_q <= misaligned_d;
            if (req_fire) begin
                pcq_mem_q[pcq_wr_q] <= pc_in;
            end
            if (rsp_keep) begin
                outq_pc_q[outq_wr_q]    <= pcq_mem_q[pcq_rd_q];
                outq_instr_q[outq_wr_q] <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: drives a PC model and a 1-cycle in-order memory model,
// collects decode handshakes and compares against hand-computed sequences.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        misaligned;

    instr_fetch_unit #(
        .DATA_WIDTH(32),
        .DEPTH     (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_in         (pc_in),
        .pc_advance    (pc_advance),
        .flush         (flush),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_fire   = 0;
    logic        mem_en;
    logic [31:0] pending   [$];
    logic [31:0] got_pc    [$];
    logic [31:0] got_instr [$];
    logic [31:0] exp_pc    [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, then update PC and memory after it.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        #1;
        fire = pc_advance;
        a    = imem_req_addr;
        if (dec_valid && dec_ready) begin
            got_pc.push_back(dec_pc);
            got_instr.push_back(dec_instr);
        end
        @(posedge clk);
        #1;
        if (fire) begin
            pending.push_back(a);
            pc_in = pc_in + 32'd4;
            n_fire++;
        end
        if (mem_en && pending.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pending.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic run_until(input string tag, input logic [31:0] target);
        for (int i = 0; i < 20 && pc_in != target; i++) tick();
        chk({tag, "_pc_reached"}, pc_in, target);
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        repeat (5) tick();
    endtask

    task automatic check_dec(input string tag);
        chk({tag, "_count"}, 32'(got_pc.size()), 32'(exp_pc.size()));
        for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
            chk($sformatf("%s_pc%0d", tag, i), got_pc[i], exp_pc[i]);
            chk($sformatf("%s_instr%0d", tag, i), got_instr[i], instr_of(exp_pc[i]));
        end
        got_pc.delete();
        got_instr.delete();
    endtask

    initial begin
        rst_n          = 1'b0;
        pc_in          = '0;
        flush          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
        mem_en         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc_advance", 32'(pc_advance), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);

        // Streaming fetch
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        #1;
        chk("run_not_set_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        run_until("stream", 32'hC);
        drain();
        exp_pc = '{32'h0, 32'h4, 32'h8};
        check_dec("stream");

        // Decode backpressure
        pc_in          = 32'h40;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b1;
        n_fire         = 0;
        repeat (6) tick();
        #1;
        chk("bp_fires", 32'(n_fire), 32'd2);
        chk("bp_req_valid_held", 32'(imem_req_valid), 32'd0);
        chk("bp_dec_valid", 32'(dec_valid), 32'd1);
        chk("bp_dec_head", dec_pc, 32'h40);
        dec_ready = 1'b1;
        run_until("bp", 32'h4C);
        drain();
        exp_pc = '{32'h40, 32'h44, 32'h48};
        check_dec("bp");

        // Memory stall
        pc_in          = 32'h10;
        imem_req_ready = 1'b0;
        n_fire         = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_addr%0d", i), imem_req_addr, 32'h10);
            chk($sformatf("stall_adv%0d", i), 32'(pc_advance), 32'd0);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        drain();
        chk("stall_fetches", 32'(n_fire), 32'd1);
        exp_pc = '{32'h10};
        check_dec("stall");

        // Flush with two fetches in flight
        pc_in          = 32'h20;
        mem_en         = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        chk("fl2_pc_after_two", pc_in, 32'h28);
        flush = 1'b1;
        #1;
        chk("fl2_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        flush  = 1'b0;
        pc_in  = 32'h100;
        mem_en = 1'b1;
        chk("fl2_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        run_until("fl2", 32'h104);
        drain();
        exp_pc = '{32'h100};
        check_dec("fl2");

        // Flush with a response landing in the flush cycle
        pc_in          = 32'h20;
        mem_en         = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        mem_en = 1'b1;
        tick();
        mem_en = 1'b0;
        flush  = 1'b1;
        #1;
        chk("flr_rsp_in_flush", 32'(imem_rsp_valid), 32'd1);
        chk("flr_dec_blocked", 32'(dec_valid), 32'd0);
        tick();
        chk("flr_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        flush  = 1'b0;
        pc_in  = 32'h100;
        mem_en = 1'b1;
        #1;
        chk("flr_target_req", 32'(imem_req_valid), 32'd1);
        chk("flr_target_addr", imem_req_addr, 32'h100);
        run_until("flr", 32'h104);
        drain();
        exp_pc = '{32'h100};
        check_dec("flr");

        // Misaligned address
        pc_in          = 32'h6;
        imem_req_ready = 1'b1;
        n_fire         = 0;
        #1;
        chk("mis_no_req", 32'(imem_req_valid), 32'd0);
        chk("mis_not_yet", 32'(misaligned), 32'd0);
        tick();
        #1;
        chk("mis_set", 32'(misaligned), 32'd1);
        tick();
        chk("mis_sticky", 32'(misaligned), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pc_in = 32'h8;
        #1;
        chk("mis_cleared", 32'(misaligned), 32'd0);
        chk("mis_target_req", 32'(imem_req_valid), 32'd1);
        run_until("mis", 32'hC);
        drain();
        chk("mis_fetches", 32'(n_fire), 32'd1);
        exp_pc = '{32'h8};
        check_dec("mis");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
